// File: rtl/uart_pkg.sv
// Shared UART-side types: FSM state encoding, byte width and a width helper.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Counter/index width; never returns less than 1 so degenerate parameters still elaborate.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request after last_grant, wrapping modulo N.
// Zero latency; purely combinational, no backpressure of its own.
module rr_pick
    import uart_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]          req,
    input  logic [clog2(N)-1:0]   last_grant,
    output logic [clog2(N)-1:0]   grant,
    output logic                  any_req
);
    localparam int W = clog2(N);

    logic [W-1:0] w_idx;
    logic         w_found;

    always_comb begin
        grant   = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int i = 1; i <= N; i++) begin
            w_idx = W'((int'(last_grant) + i) % N);
            if (!w_found && req[w_idx]) begin
                grant   = w_idx;
                w_found = 1'b1;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin share of one uart_tx byte port; 1-cycle arbitration, then a
// combinational passthrough where the granted requester's ready follows tx_ready, others stall.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = UART_DATA_W,
    parameter int GAP_CYCLES  = 16,
    parameter int MAX_MSG_LEN = 256
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic [NUM_REQ-1:0]          req_last,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [DATA_W-1:0]           tx_data,
    output logic                        tx_valid,
    input  logic                        tx_ready,
    output logic                        busy,
    output logic [clog2(NUM_REQ)-1:0]   grant_id,
    output logic                        overflow_err
);
    localparam int GW  = clog2(NUM_REQ);
    localparam int BCW = clog2(MAX_MSG_LEN + 1);
    localparam int GCW = clog2(GAP_CYCLES + 1);
    localparam logic [BCW-1:0] LP_BC_LAST  = BCW'(MAX_MSG_LEN - 1);
    localparam logic [GCW-1:0] LP_GAP_LOAD = GCW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t         r_state;
    logic [GW-1:0]  r_grant;
    logic [GW-1:0]  r_last_grant;
    logic [BCW-1:0] r_byte_cnt;
    logic [GCW-1:0] r_gap_cnt;
    logic           r_ovf;

    logic [GW-1:0]  w_pick;
    logic           w_any;
    logic           w_send;
    logic           w_hs;
    logic           w_last;
    logic           w_overflow;
    logic           w_release;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req        (req_valid),
        .last_grant (r_last_grant),
        .grant      (w_pick),
        .any_req    (w_any)
    );

    assign w_send     = (r_state == ST_SEND);
    assign tx_valid   = w_send & req_valid[r_grant];
    assign tx_data    = tx_valid ? req_data[int'(r_grant)*DATA_W +: DATA_W] : '0;
    assign w_hs       = tx_valid & tx_ready;
    assign w_last     = req_last[r_grant];
    // A message reaching the length cap is cut here; its tail re-arbitrates as a fresh message.
    assign w_overflow = w_hs & ~w_last & (r_byte_cnt == LP_BC_LAST);
    assign w_release  = (w_hs & w_last) | w_overflow;

    assign busy         = (r_state != ST_IDLE);
    assign grant_id     = r_grant;
    assign overflow_err = r_ovf;

    always_comb begin
        req_ready = '0;
        if (w_send) req_ready[r_grant] = tx_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_last_grant <= GW'(NUM_REQ - 1);
            r_byte_cnt   <= '0;
            r_gap_cnt    <= '0;
            r_ovf        <= 1'b0;
        end else begin
            r_ovf <= w_overflow;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_pick;
                        r_state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (w_release) begin
                        r_last_grant <= r_grant;
                        r_byte_cnt   <= '0;
                        r_gap_cnt    <= LP_GAP_LOAD;
                        r_state      <= (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
                    end else if (w_hs) begin
                        r_byte_cnt <= r_byte_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == '0) r_state <= ST_IDLE;
                    else                 r_gap_cnt <= r_gap_cnt - 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
